// File: rtl/axis_frame_len_stats_pkg.sv
// Shared definitions for the AXI-Stream frame length monitor.
package axis_frame_len_stats_pkg;

  // frame_len_tuser bit positions
  localparam int unsigned TUSER_ERR   = 0;
  localparam int unsigned TUSER_SAT   = 1;
  localparam int unsigned TUSER_WIDTH = 2;

  // KEEP_MODE encodings
  localparam int unsigned KEEP_MODE_CONTIG = 0;
  localparam int unsigned KEEP_MODE_POPCNT = 1;

  // Widest tkeep the byte counter handles; narrower keeps are zero-extended
  localparam int unsigned KEEP_MAX    = 128;
  localparam int unsigned BYTES_WIDTH = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic                   noncontig;
    logic [BYTES_WIDTH-1:0] bytes;
  } keep_bytes_t;

  // Byte count of one beat: low-aligned run length (contiguous) or popcount
  function automatic keep_bytes_t keep_to_bytes(input logic [KEEP_MAX-1:0] keep,
                                                input int unsigned         mode);
    logic [BYTES_WIDTH-1:0] ones;
    logic [BYTES_WIDTH-1:0] run;
    logic                   seen_zero;
    logic                   gap;
    keep_bytes_t            res;
    ones      = '0;
    run       = '0;
    seen_zero = 1'b0;
    gap       = 1'b0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (keep[i]) begin
        ones = ones + BYTES_WIDTH'(1);
        if (seen_zero) gap = 1'b1;
        else           run = run + BYTES_WIDTH'(1);
      end else begin
        seen_zero = 1'b1;
      end
    end
    if (mode == KEEP_MODE_POPCNT) begin
      res.bytes     = ones;
      res.noncontig = 1'b0;
    end else begin
      res.bytes     = gap ? '0 : run;
      res.noncontig = gap;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_frame_len_fifo.sv
// Shift-register result queue; head entry is a flop, push allowed when full if popping.
module axis_frame_len_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] wr_pos;
  logic             do_pop;
  logic             do_push;

  // Accepted operations, write slot and next occupancy
  always_comb begin
    do_pop     = pop && valid;
    do_push    = push && (!full || do_pop);
    wr_pos     = do_pop ? (count - CNT_W'(1)) : count;
    count_next = count;
    if (do_push && !do_pop)      count_next = count + CNT_W'(1);
    else if (do_pop && !do_push) count_next = count - CNT_W'(1);
  end

  // Storage shift on pop, write behind the last live entry on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
      valid <= 1'b0;
      full  <= 1'b0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (do_push) mem[IDX_W'(wr_pos)] <= din;
      count <= count_next;
      valid <= (count_next != '0);
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

  assign dout = mem[0];

endmodule

// File: rtl/axis_frame_len_stats.sv
// Passive AXI-Stream frame length monitor with statistics and a result queue.
module axis_frame_len_stats
  import axis_frame_len_stats_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned KEEP_MODE   = 0,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic                  monitor_axis_tvalid,
  input  logic                  monitor_axis_tready,
  input  logic                  monitor_axis_tlast,
  input  logic                  monitor_axis_tuser,
  output logic [LEN_WIDTH-1:0]  frame_len_tdata,
  output logic [1:0]            frame_len_tuser,
  output logic                  frame_len_tvalid,
  input  logic                  frame_len_tready,
  input  logic                  stat_clear,
  output logic [CNT_WIDTH-1:0]  stat_frame_count,
  output logic [CNT_WIDTH-1:0]  stat_drop_count,
  output logic [CNT_WIDTH-1:0]  stat_err_count,
  output logic [LEN_WIDTH-1:0]  stat_len_max,
  output logic [LEN_WIDTH-1:0]  stat_len_min,
  output logic                  busy
);

  localparam int unsigned SUM_WIDTH = LEN_WIDTH + 1;
  localparam int unsigned RES_WIDTH = LEN_WIDTH + TUSER_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_ONES = {LEN_WIDTH{1'b1}};

  ctrl_state_t            state;
  ctrl_state_t            state_next;
  logic [LEN_WIDTH-1:0]   acc;
  logic                   err;
  logic                   sat;
  logic                   beat;
  logic                   frame_done;
  keep_bytes_t            keep_info;
  logic [BYTES_WIDTH-1:0] beat_bytes;
  logic [SUM_WIDTH-1:0]   acc_sum;
  logic                   overflow;
  logic [LEN_WIDTH-1:0]   acc_next;
  logic                   sat_next;
  logic                   err_next;
  logic [RES_WIDTH-1:0]   result;
  logic [RES_WIDTH-1:0]   head;
  logic                   fifo_full;
  logic                   pop;
  logic                   drop;

  logic [CNT_WIDTH-1:0]   frame_cnt_next;
  logic [CNT_WIDTH-1:0]   drop_cnt_next;
  logic [CNT_WIDTH-1:0]   err_cnt_next;
  logic [LEN_WIDTH-1:0]   len_max_next;
  logic [LEN_WIDTH-1:0]   len_min_next;

  // Beat byte count and saturating accumulation including the current beat
  always_comb begin
    beat       = monitor_axis_tvalid && monitor_axis_tready;
    frame_done = beat && monitor_axis_tlast;
    keep_info  = keep_to_bytes(KEEP_MAX'(monitor_axis_tkeep), KEEP_MODE);
    beat_bytes = (KEEP_ENABLE != 0) ? keep_info.bytes : BYTES_WIDTH'(1);
    acc_sum    = {1'b0, acc} + SUM_WIDTH'(beat_bytes);
    overflow   = acc_sum[LEN_WIDTH];
    acc_next   = overflow ? LEN_ONES : acc_sum[LEN_WIDTH-1:0];
    sat_next   = sat | overflow;
    err_next   = err | monitor_axis_tuser |
                 ((KEEP_ENABLE != 0) && (KEEP_MODE == KEEP_MODE_CONTIG) && keep_info.noncontig);
    result     = {err_next, sat_next, acc_next};
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state: a frame is in progress after any non-last beat
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (beat && !monitor_axis_tlast) state_next = ST_ACTIVE;
      ST_ACTIVE: if (frame_done)                  state_next = ST_IDLE;
      default:                                    state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_ACTIVE);

  // Per-frame accumulator and sticky flags; tlast restarts with no gap cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      err <= 1'b0;
      sat <= 1'b0;
    end else if (beat) begin
      if (monitor_axis_tlast) begin
        acc <= '0;
        err <= 1'b0;
        sat <= 1'b0;
      end else begin
        acc <= acc_next;
        err <= err_next;
        sat <= sat_next;
      end
    end
  end

  assign pop  = frame_len_tvalid && frame_len_tready;
  assign drop = frame_done && fifo_full && !pop;

  axis_frame_len_fifo #(
    .WIDTH (RES_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (frame_done),
    .din   (result),
    .pop   (pop),
    .dout  (head),
    .valid (frame_len_tvalid),
    .full  (fifo_full)
  );

  assign frame_len_tdata            = head[LEN_WIDTH-1:0];
  assign frame_len_tuser[TUSER_ERR] = head[LEN_WIDTH+1];
  assign frame_len_tuser[TUSER_SAT] = head[LEN_WIDTH];

  // Statistics next values: clear first, then apply a completing frame on top
  always_comb begin
    frame_cnt_next = stat_clear ? '0       : stat_frame_count;
    drop_cnt_next  = stat_clear ? '0       : stat_drop_count;
    err_cnt_next   = stat_clear ? '0       : stat_err_count;
    len_max_next   = stat_clear ? '0       : stat_len_max;
    len_min_next   = stat_clear ? LEN_ONES : stat_len_min;
    if (frame_done) begin
      frame_cnt_next = frame_cnt_next + CNT_WIDTH'(1);
      drop_cnt_next  = drop_cnt_next + CNT_WIDTH'(drop);
      err_cnt_next   = err_cnt_next + CNT_WIDTH'(err_next);
      if (acc_next > len_max_next) len_max_next = acc_next;
      if (acc_next < len_min_next) len_min_next = acc_next;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frame_count <= '0;
      stat_drop_count  <= '0;
      stat_err_count   <= '0;
      stat_len_max     <= '0;
      stat_len_min     <= LEN_ONES;
    end else begin
      stat_frame_count <= frame_cnt_next;
      stat_drop_count  <= drop_cnt_next;
      stat_err_count   <= err_cnt_next;
      stat_len_max     <= len_max_next;
      stat_len_min     <= len_min_next;
    end
  end

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Bench for axis_frame_len_stats: two configurations share one stimulus stream
// and are checked every cycle against a frame-level reference model.
module tb_axis_frame_len_stats;

  localparam int DEPTH = 4;
  localparam int QSZ   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tkeep = '0;
  logic       tvalid = 1'b0;
  logic       tready = 1'b1;
  logic       tlast = 1'b0;
  logic       tuser = 1'b0;
  logic       out_ready = 1'b1;
  logic       stat_clear = 1'b0;

  logic [15:0] a_tdata;  logic [1:0] a_tuser;  logic a_tvalid;  logic a_busy;
  logic [31:0] a_fc, a_dc, a_ec;  logic [15:0] a_max, a_min;
  logic [7:0]  b_tdata;  logic [1:0] b_tuser;  logic b_tvalid;  logic b_busy;
  logic [31:0] b_fc, b_dc, b_ec;  logic [7:0]  b_max, b_min;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axis_frame_len_stats #(
    .DATA_WIDTH(64), .KEEP_MODE(0), .LEN_WIDTH(16), .CNT_WIDTH(32), .FIFO_DEPTH(DEPTH)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid), .monitor_axis_tready(tready),
    .monitor_axis_tlast(tlast), .monitor_axis_tuser(tuser),
    .frame_len_tdata(a_tdata), .frame_len_tuser(a_tuser), .frame_len_tvalid(a_tvalid),
    .frame_len_tready(out_ready), .stat_clear(stat_clear),
    .stat_frame_count(a_fc), .stat_drop_count(a_dc), .stat_err_count(a_ec),
    .stat_len_max(a_max), .stat_len_min(a_min), .busy(a_busy)
  );

  axis_frame_len_stats #(
    .DATA_WIDTH(64), .KEEP_MODE(1), .LEN_WIDTH(8), .CNT_WIDTH(32), .FIFO_DEPTH(DEPTH)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid), .monitor_axis_tready(tready),
    .monitor_axis_tlast(tlast), .monitor_axis_tuser(tuser),
    .frame_len_tdata(b_tdata), .frame_len_tuser(b_tuser), .frame_len_tvalid(b_tvalid),
    .frame_len_tready(out_ready), .stat_clear(stat_clear),
    .stat_frame_count(b_fc), .stat_drop_count(b_dc), .stat_err_count(b_ec),
    .stat_len_max(b_max), .stat_len_min(b_min), .busy(b_busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ----------------
  int m_total [2];
  bit m_err   [2];
  bit m_busy  [2];
  int q_len   [2][QSZ];
  int q_usr   [2][QSZ];
  int q_head  [2];
  int q_cnt   [2];
  int m_frames[2];
  int m_drops [2];
  int m_errs  [2];
  int m_max   [2];
  int m_min   [2];

  function automatic int len_cap(input int i);
    return (i == 0) ? 65535 : 255;
  endfunction

  function automatic int beat_len(input int i, input logic [7:0] k, output bit bad);
    int n;
    n   = $countones(k);
    bad = 1'b0;
    if (i == 1) return n;
    if (int'(k) != (1 << n) - 1) begin
      bad = 1'b1;
      return 0;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_total[i] = 0; m_err[i] = 0; m_busy[i] = 0;
      q_head[i] = 0;  q_cnt[i] = 0;
      m_frames[i] = 0; m_drops[i] = 0; m_errs[i] = 0;
      m_max[i] = 0;    m_min[i] = len_cap(i);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit full, pop, bad, sat;
      int b, len;
      full = (q_cnt[i] == DEPTH);
      pop  = (q_cnt[i] > 0) && out_ready;
      if (pop) begin
        q_head[i] = (q_head[i] + 1) % QSZ;
        q_cnt[i]--;
      end
      if (stat_clear) begin
        m_frames[i] = 0; m_drops[i] = 0; m_errs[i] = 0;
        m_max[i] = 0;    m_min[i] = len_cap(i);
      end
      if (tvalid && tready) begin
        b = beat_len(i, tkeep, bad);
        m_total[i] += b;
        m_err[i] = m_err[i] | tuser | bad;
        if (tlast) begin
          sat = (m_total[i] > len_cap(i));
          len = sat ? len_cap(i) : m_total[i];
          if (!full || pop) begin
            q_len[i][(q_head[i] + q_cnt[i]) % QSZ] = len;
            q_usr[i][(q_head[i] + q_cnt[i]) % QSZ] = int'(m_err[i]) + 2 * int'(sat);
            q_cnt[i]++;
          end else begin
            m_drops[i]++;
          end
          m_frames[i]++;
          m_errs[i] += int'(m_err[i]);
          if (len > m_max[i]) m_max[i] = len;
          if (len < m_min[i]) m_min[i] = len;
          m_total[i] = 0;
          m_err[i]   = 0;
          m_busy[i]  = 0;
        end else begin
          m_busy[i] = 1;
        end
      end
    end
  endtask

  task automatic compare_inst(input int i, input int valid, input int data, input int usr,
                              input int fc, input int dc, input int ec, input int mx,
                              input int mn, input int bsy);
    string p;
    p = (i == 0) ? "a" : "b";
    check({p, "_tvalid"}, valid, int'(q_cnt[i] > 0));
    if (q_cnt[i] > 0) begin
      check({p, "_tdata"}, data, q_len[i][q_head[i]]);
      check({p, "_tuser"}, usr, q_usr[i][q_head[i]]);
    end
    check({p, "_frame_count"}, fc, m_frames[i]);
    check({p, "_drop_count"}, dc, m_drops[i]);
    check({p, "_err_count"}, ec, m_errs[i]);
    check({p, "_len_max"}, mx, m_max[i]);
    check({p, "_len_min"}, mn, m_min[i]);
    check({p, "_busy"}, bsy, int'(m_busy[i]));
  endtask

  // Every-cycle compare: advance model on the edge, compare 1 time unit later
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    compare_inst(0, int'(a_tvalid), int'(a_tdata), int'(a_tuser), int'(a_fc), int'(a_dc),
                 int'(a_ec), int'(a_max), int'(a_min), int'(a_busy));
    compare_inst(1, int'(b_tvalid), int'(b_tdata), int'(b_tuser), int'(b_fc), int'(b_dc),
                 int'(b_ec), int'(b_max), int'(b_min), int'(b_busy));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [7:0] k, input logic v, input logic l, input logic u);
    tkeep = k; tvalid = v; tlast = l; tuser = u;
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_keep();
    logic [7:0] k;
    case ($urandom % 6)
      0:       k = 8'hFF;
      1:       k = 8'((1 << ($urandom % 9)) - 1);
      2:       k = 8'($urandom);
      3:       k = 8'h00;
      default: k = 8'hFF;
    endcase
    return k;
  endfunction

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a_tvalid", int'(a_tvalid), 0);
    check("reset_a_tdata", int'(a_tdata), 0);
    check("reset_a_min", int'(a_min), 65535);
    check("reset_b_min", int'(b_min), 255);
    check("reset_a_busy", int'(a_busy), 0);
    rst_n = 1'b1;

    // 3-beat frame FF,FF,0F -> 20 bytes
    cyc(8'hFF, 1, 0, 0);
    cyc(8'hFF, 1, 0, 0);
    check("t1_busy", int'(a_busy), 1);
    cyc(8'h0F, 1, 1, 0);
    check("t1_a_tvalid", int'(a_tvalid), 1);
    check("t1_a_tdata", int'(a_tdata), 20);
    check("t1_a_tuser", int'(a_tuser), 0);
    check("t1_a_frames", int'(a_fc), 1);
    check("t1_a_max", int'(a_max), 20);
    check("t1_a_min", int'(a_min), 20);
    check("t1_b_tdata", int'(b_tdata), 20);
    check("t1_busy_end", int'(a_busy), 0);
    cyc(8'h00, 0, 0, 0);

    // 40 full beats: 320 bytes, saturates the 8-bit instance
    repeat (39) cyc(8'hFF, 1, 0, 0);
    cyc(8'hFF, 1, 1, 0);
    check("t2_b_tdata", int'(b_tdata), 255);
    check("t2_b_tuser", int'(b_tuser), 2);
    check("t2_a_tdata", int'(a_tdata), 320);
    check("t2_a_tuser", int'(a_tuser), 0);
    cyc(8'h00, 0, 0, 0);

    // Non-contiguous keep mid-frame
    cyc(8'hFF, 1, 0, 0);
    cyc(8'h05, 1, 0, 0);
    cyc(8'h0F, 1, 1, 0);
    check("t3_a_tdata", int'(a_tdata), 12);
    check("t3_a_tuser", int'(a_tuser), 1);
    check("t3_a_errs", int'(a_ec), 1);
    check("t3_b_tdata", int'(b_tdata), 14);
    check("t3_b_tuser", int'(b_tuser), 0);
    check("t3_b_errs", int'(b_ec), 0);
    cyc(8'h00, 0, 0, 0);

    // Queue overflow: 6 single-beat frames of 1..6 bytes with ready low
    stat_clear = 1'b1;
    cyc(8'h00, 0, 0, 0);
    stat_clear = 1'b0;
    out_ready  = 1'b0;
    for (int k = 1; k <= 6; k++) cyc(8'((1 << k) - 1), 1, 1, 0);
    check("t4_a_frames", int'(a_fc), 6);
    check("t4_a_drops", int'(a_dc), 2);
    check("t4_b_drops", int'(b_dc), 2);
    check("t4_a_max", int'(a_max), 6);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("t4_drain_valid", int'(a_tvalid), 1);
      check("t4_drain_tdata", int'(a_tdata), k);
      cyc(8'h00, 0, 0, 0);
    end
    check("t4_drained", int'(a_tvalid), 0);

    // stat_clear coincident with the tlast of a 64-byte frame
    repeat (7) cyc(8'hFF, 1, 0, 0);
    stat_clear = 1'b1;
    cyc(8'hFF, 1, 1, 0);
    stat_clear = 1'b0;
    check("t5_frames", int'(a_fc), 1);
    check("t5_max", int'(a_max), 64);
    check("t5_min", int'(a_min), 64);
    check("t5_drops", int'(a_dc), 0);
    cyc(8'h00, 0, 0, 0);

    // Reset during beat 2 of 4
    cyc(8'hFF, 1, 0, 0);
    tkeep = 8'hFF; tvalid = 1'b1; tlast = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    tvalid = 1'b0;
    check("t6_rst_tvalid", int'(a_tvalid), 0);
    check("t6_rst_busy", int'(a_busy), 0);
    check("t6_rst_frames", int'(a_fc), 0);
    check("t6_rst_max", int'(a_max), 0);
    check("t6_rst_min", int'(a_min), 65535);
    rst_n = 1'b1;
    cyc(8'hFF, 1, 0, 0);
    cyc(8'hFF, 1, 1, 0);
    check("t6_tdata", int'(a_tdata), 16);
    check("t6_frames", int'(a_fc), 1);

    // Back-to-back single-beat frames
    for (int k = 0; k < 6; k++) cyc(rand_keep(), 1, 1, 0);
    cyc(8'h00, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tready     = ($urandom % 4) != 0;
      out_ready  = ($urandom % 2) != 0;
      stat_clear = ($urandom % 64) == 0;
      cyc(rand_keep(), ($urandom % 4) != 0,
          ($urandom % ((n >= 2000) ? 40 : 4)) == 0, ($urandom % 16) == 0);
    end
    tready = 1'b1; out_ready = 1'b1; stat_clear = 1'b0;
    repeat (8) cyc(8'h00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
